// File: rtl/regfile_pkg.sv
// Shared constants for the soft-clear register file: default geometry,
// clear-FSM state encoding and the clear termination index.
package regfile_pkg;

   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned WIDTH_DEF  = 32;

   // Clear FSM encoding
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   // Highest register index for a given address width; the clear stops here
   function automatic int unsigned last_index(input int unsigned aw);
      return (1 << aw) - 1;
   endfunction

   localparam int unsigned LAST_IDX_DEF = (1 << ADDR_W_DEF) - 1;

endpackage

// File: rtl/regfile_cell.sv
// One storage register of the register file: async active-low reset,
// write enable and a synchronous zero input that wins over the write.
module regfile_cell
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             we_i,
   input  logic             zero_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   // Next value: clear has priority, then write, otherwise hold
   always_comb begin
      data_d = data_q;
      if (zero_i) begin
         data_d = '0;
      end else if (we_i) begin
         data_d = d_i;
      end
   end

   // Storage with asynchronous reset to zero
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/regfile_clr.sv
// 2-read/1-write register file with a sequential soft-clear engine.
// Register 0 reads as zero. ClearAll zeroes r1..r(last), one per cycle,
// while Busy blocks writes and further clear requests.
// Optional build macro: REGFILE_BYPASS_EN (write-through read bypass).
module regfile_clr
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH  = WIDTH_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [ADDR_W-1:0] ReadRegister1,
   input  logic [ADDR_W-1:0] ReadRegister2,
   output logic [WIDTH-1:0]  ReadData1,
   output logic [WIDTH-1:0]  ReadData2,
   input  logic [ADDR_W-1:0] WriteRegister,
   input  logic [WIDTH-1:0]  WriteData,
   input  logic              RegWrite,
   input  logic              ClearAll,
   output logic              Busy
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(last_index(ADDR_W));
   localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

   logic [0:0]        state_q;
   logic [0:0]        state_d;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W-1:0] ptr_d;

   logic [WIDTH-1:0]  regs [DEPTH];
   logic              wr_ok;
   logic              clearing;

   assign clearing = (state_q == ST_CLEAR);
   assign Busy     = clearing;
   assign wr_ok    = RegWrite && !clearing && (WriteRegister != '0);

   // Register 0 is a constant zero, never stored
   assign regs[0] = '0;

   genvar g;
   generate
      for (g = 1; g < DEPTH; g++) begin : g_cell
         logic we;
         logic zero;
         assign we   = wr_ok && (WriteRegister == ADDR_W'(g));
         assign zero = clearing && (ptr_q == ADDR_W'(g));

         regfile_cell #(
            .WIDTH (WIDTH)
         ) u_cell (
            .clk_i  (Clk),
            .rst_ni (Reset_n),
            .we_i   (we),
            .zero_i (zero),
            .d_i    (WriteData),
            .q_o    (regs[g])
         );
      end
   endgenerate

   // Clear FSM next state: IDLE waits for ClearAll, CLEAR walks the pointer
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (ClearAll) begin
               state_d = ST_CLEAR;
               ptr_d   = FIRST_IDX;
            end
         end
         ST_CLEAR: begin
            if (ptr_q == LAST_IDX) begin
               state_d = ST_IDLE;
               ptr_d   = FIRST_IDX;
            end else begin
               ptr_d = ptr_q + FIRST_IDX;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ptr_d   = FIRST_IDX;
         end
      endcase
   end

   // Clear FSM state and pointer registers
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= FIRST_IDX;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Combinational read ports; address 0 resolves to the constant zero entry
   always_comb begin
      ReadData1 = regs[ReadRegister1];
      ReadData2 = regs[ReadRegister2];
`ifdef REGFILE_BYPASS_EN
      // wr_ok already excludes address 0, so r0 keeps reading zero
      if (wr_ok && (ReadRegister1 == WriteRegister)) begin
         ReadData1 = WriteData;
      end
      if (wr_ok && (ReadRegister2 == WriteRegister)) begin
         ReadData2 = WriteData;
      end
`endif
   end

endmodule

// File: tb/tb_regfile_clr.sv
// Directed self-checking bench for regfile_clr.
module tb_regfile_clr;

   logic        Clk;
   logic        Reset_n;
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic [4:0]  WriteRegister;
   logic [31:0] WriteData;
   logic        RegWrite;
   logic        ClearAll;
   logic        Busy;

   int checks;
   int failures;

   regfile_clr #(
      .WIDTH  (32),
      .ADDR_W (5)
   ) dut (
      .Clk           (Clk),
      .Reset_n       (Reset_n),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .ReadData1     (ReadData1),
      .ReadData2     (ReadData2),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .RegWrite      (RegWrite),
      .ClearAll      (ClearAll),
      .Busy          (Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge, then settle
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      RegWrite = 1'b1;
      WriteRegister = a;
      WriteData = d;
      tick();
      RegWrite = 1'b0;
   endtask

   task automatic rd1(input logic [4:0] a);
      ReadRegister1 = a;
      #1;
   endtask

   initial begin
      int n;
      checks = 0;
      failures = 0;
      Reset_n = 1'b0;
      ReadRegister1 = '0;
      ReadRegister2 = '0;
      WriteRegister = '0;
      WriteData = '0;
      RegWrite = 1'b0;
      ClearAll = 1'b0;

      // Reset state
      #12;
      ReadRegister1 = 5'd7;
      #1;
      chk("reset_busy", {31'd0, Busy}, 32'd0);
      chk("reset_r7", ReadData1, 32'd0);
      Reset_n = 1'b1;
      tick();

      // Basic writes and dual reads
      wr(5'd2, 32'd42);
      wr(5'd3, 32'd15);
      ReadRegister1 = 5'd2;
      ReadRegister2 = 5'd3;
      #1;
      chk("rd_r2_p1", ReadData1, 32'd42);
      chk("rd_r3_p2", ReadData2, 32'd15);
      ReadRegister1 = 5'd3;
      #1;
      chk("same_r3_p1", ReadData1, 32'd15);
      chk("same_r3_p2", ReadData2, 32'd15);

      // RegWrite=0 does nothing
      RegWrite = 1'b0;
      WriteRegister = 5'd1;
      WriteData = 32'd42;
      tick();
      rd1(5'd1);
      chk("nowe_r1", ReadData1, 32'd0);

      // Write to r0 discarded
      wr(5'd0, 32'd42);
      rd1(5'd0);
      chk("r0_zero", ReadData1, 32'd0);

      // Fill r1..r31 with 0x100+n
      for (int i = 1; i < 32; i++) wr(5'(i), 32'h100 + 32'(i));
      rd1(5'd17);
      chk("fill_r17", ReadData1, 32'h111);

      // Clear sequence
      ClearAll = 1'b1;
      tick();
      ClearAll = 1'b0;
      chk("clr_busy_start", {31'd0, Busy}, 32'd1);
      for (int i = 0; i < 5; i++) tick();
      for (int i = 1; i <= 5; i++) begin
         rd1(5'(i));
         chk($sformatf("clr5_r%0d", i), ReadData1, 32'd0);
      end
      rd1(5'd6);
      chk("clr5_r6", ReadData1, 32'h106);
      n = 5;
      while (Busy && n < 100) begin
         tick();
         n++;
      end
      // n counts edges after the start edge while Busy was high -> 31 cycles
      chk("clr_busy_cycles", 32'(n), 32'd31);
      begin
         logic bad;
         bad = 1'b0;
         for (int i = 0; i < 32; i++) begin
            rd1(5'(i));
            if (ReadData1 !== 32'd0) bad = 1'b1;
         end
         chk("clr_all_zero", {31'd0, bad}, 32'd0);
      end

      // Dropped write and ignored ClearAll during CLEAR
      wr(5'd31, 32'h11F);
      ClearAll = 1'b1;
      tick();
      ClearAll = 1'b0;
      tick();
      tick();
      RegWrite = 1'b1;
      WriteRegister = 5'd31;
      WriteData = 32'hDEAD;
      ClearAll = 1'b1;
      tick();
      RegWrite = 1'b0;
      ClearAll = 1'b0;
      rd1(5'd31);
      chk("drop_r31_old", ReadData1, 32'h11F);
      n = 3;
      while (Busy && n < 100) begin
         tick();
         n++;
      end
      chk("drop_busy_cycles", 32'(n), 32'd31);
      rd1(5'd31);
      chk("drop_r31_end", ReadData1, 32'd0);

      // Async reset mid-clear
      wr(5'd9, 32'd7);
      ClearAll = 1'b1;
      tick();
      ClearAll = 1'b0;
      tick();
      tick();
      ReadRegister1 = 5'd9;
      #1;
      chk("rst_pre_r9", ReadData1, 32'd7);
      #1;
      Reset_n = 1'b0;
      #1;
      chk("rst_busy", {31'd0, Busy}, 32'd0);
      chk("rst_r9", ReadData1, 32'd0);
      #1;
      Reset_n = 1'b1;
      tick();
      chk("rst_idle", {31'd0, Busy}, 32'd0);
      wr(5'd9, 32'd5);
      rd1(5'd9);
      chk("rst_wr_r9", ReadData1, 32'd5);

      // Bypass / no-bypass behaviour before the edge
      RegWrite = 1'b1;
      WriteRegister = 5'd4;
      WriteData = 32'd99;
      ReadRegister1 = 5'd4;
      ReadRegister2 = 5'd0;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("pre_edge_r4", ReadData1, 32'd99);
`else
      chk("pre_edge_r4", ReadData1, 32'd0);
`endif
      chk("pre_edge_r0", ReadData2, 32'd0);
      tick();
      RegWrite = 1'b0;
      #1;
      chk("post_edge_r4", ReadData1, 32'd99);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
